// File: rtl/core_pkt_ingress_pkg.sv
// Shared types and defaults for the per-core packet ingress buffer.
// Optional statistics are enabled by defining CORE_PKT_INGRESS_STATS_EN.
package core_pkt_ingress_pkg;

    localparam int DATA_WIDTH_DEF    = 64;
    localparam int ROUTE_WIDTH_DEF   = 24;
    localparam int ADDR_WIDTH_DEF    = 9;
    localparam int MAX_PKT_WORDS_DEF = 192;
    localparam int DESC_DEPTH_DEF    = 4;
    localparam int LEN_WIDTH         = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RECV    = 2'd2,
        ST_RELEASE = 2'd3
    } wr_state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/core_pkt_ingress_if.sv
// Classifier lane and core-side signals of the packet ingress buffer.
interface core_pkt_ingress_if
    import core_pkt_ingress_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int ROUTE_WIDTH = ROUTE_WIDTH_DEF
);
    logic [DATA_WIDTH-1:0]  in_data;
    logic [ROUTE_WIDTH-1:0] in_pkt_route;
    logic                   in_wr;
    logic                   in_req;
    logic                   in_ack;
    logic                   in_bypass;
    logic                   in_protocol;

    logic                   pkt_avail;
    logic [LEN_WIDTH-1:0]   pkt_len;
    logic [ROUTE_WIDTH-1:0] pkt_route;
    logic                   pkt_bypass;
    logic                   pkt_protocol;
    logic                   pkt_trunc;
    logic                   core_rd;
    logic [DATA_WIDTH-1:0]  core_data;
    logic                   core_vld;
    logic                   core_eop;

    modport slave (
        input  in_data, in_pkt_route, in_wr, in_req, in_bypass, in_protocol, core_rd,
        output in_ack, pkt_avail, pkt_len, pkt_route, pkt_bypass, pkt_protocol, pkt_trunc,
               core_data, core_vld, core_eop
    );

    modport master (
        output in_data, in_pkt_route, in_wr, in_req, in_bypass, in_protocol, core_rd,
        input  in_ack, pkt_avail, pkt_len, pkt_route, pkt_bypass, pkt_protocol, pkt_trunc,
               core_data, core_vld, core_eop
    );
endinterface

// File: rtl/core_pkt_ingress_pkt_word_ram.sv
// Simple dual-port packet word RAM: one write port, one registered read port.
module pkt_word_ram #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/core_pkt_ingress.sv
// Per-core packet ingress buffer: lane handshake, packet word RAM, descriptor FIFO, core read side.
// Define CORE_PKT_INGRESS_STATS_EN to add the stat_pkts/stat_trunc/stat_stall counters.
module core_pkt_ingress
    import core_pkt_ingress_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int ROUTE_WIDTH   = ROUTE_WIDTH_DEF,
    parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF,
    parameter int MAX_PKT_WORDS = MAX_PKT_WORDS_DEF,
    parameter int DESC_DEPTH    = DESC_DEPTH_DEF
) (
    input  logic               clk,
    input  logic               reset,
    core_pkt_ingress_if.slave  bus
`ifdef CORE_PKT_INGRESS_STATS_EN
    ,
    output logic [31:0]        stat_pkts,
    output logic [31:0]        stat_trunc,
    output logic [31:0]        stat_stall
`endif
);
    localparam int PTR_W = ADDR_WIDTH + 1;
    localparam int DAW   = $clog2(DESC_DEPTH);
    localparam int DPW   = DAW + 1;
    localparam logic [PTR_W-1:0]     RAM_WORDS   = PTR_W'(1 << ADDR_WIDTH);
    localparam logic [PTR_W-1:0]     ADMIT_WORDS = PTR_W'(MAX_PKT_WORDS);
    localparam logic [LEN_WIDTH-1:0] MAX_LEN     = LEN_WIDTH'(MAX_PKT_WORDS);

    typedef struct packed {
        logic [LEN_WIDTH-1:0]   len;
        logic [ROUTE_WIDTH-1:0] route;
        logic                   bypass;
        logic                   protocol;
        logic                   trunc;
    } desc_t;

    wr_state_e              state_q, state_d;
    logic                   ack_q, ack_d;
    logic [PTR_W-1:0]       wptr_q, wptr_d;
    logic [LEN_WIDTH-1:0]   wcnt_q, wcnt_d;
    logic                   trunc_q, trunc_d;
    logic [ROUTE_WIDTH-1:0] route_q, route_d;
    logic                   bypass_q, bypass_d;

    logic [PTR_W-1:0]       rptr_q, rptr_d;
    logic [LEN_WIDTH-1:0]   rcnt_q, rcnt_d;
    logic                   vld_q, vld_d;
    logic                   eop_q, eop_d;
    logic [DPW-1:0]         dwr_q, dwr_d;
    logic [DPW-1:0]         drd_q, drd_d;

    desc_t                  desc_mem [DESC_DEPTH];
    desc_t                  head;
    desc_t                  push_desc;
    logic                   push, pop;
    logic                   desc_full, desc_empty;
    logic [PTR_W-1:0]       used_words, free_words;
    logic                   ram_we, rd_fire, rd_last;
    logic [ADDR_WIDTH-1:0]  waddr, raddr;
    logic [DATA_WIDTH-1:0]  ram_rdata;

    assign desc_empty = (dwr_q == drd_q);
    assign desc_full  = (dwr_q[DAW] != drd_q[DAW]) && (dwr_q[DAW-1:0] == drd_q[DAW-1:0]);
    assign head       = desc_mem[drd_q[DAW-1:0]];

    // Space is released only when the core consumes eop, so this view is conservative.
    assign used_words = wptr_q - rptr_q;
    assign free_words = RAM_WORDS - used_words;

    assign waddr = wptr_q[ADDR_WIDTH-1:0] + ADDR_WIDTH'(wcnt_q);
    assign raddr = rptr_q[ADDR_WIDTH-1:0] + ADDR_WIDTH'(rcnt_q);

    always_comb begin
        state_d  = state_q;
        wptr_d   = wptr_q;
        wcnt_d   = wcnt_q;
        trunc_d  = trunc_q;
        route_d  = route_q;
        bypass_d = bypass_q;
        push     = 1'b0;
        ram_we   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_req && (free_words >= ADMIT_WORDS) && !desc_full) begin
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                route_d  = bus.in_pkt_route;
                bypass_d = bus.in_bypass;
                wcnt_d   = '0;
                trunc_d  = 1'b0;
                state_d  = bus.in_req ? ST_RECV : ST_RELEASE;
            end
            ST_RECV: begin
                if (!bus.in_req) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (wcnt_q != '0) begin
                    push   = 1'b1;
                    wptr_d = wptr_q + PTR_W'(wcnt_q);
                end
                wcnt_d  = '0;
                trunc_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // The lane is open as soon as in_ack is visible, so GRANT accepts a word too.
        if ((state_q == ST_GRANT || state_q == ST_RECV) && bus.in_req && bus.in_wr) begin
            if (wcnt_q < MAX_LEN) begin
                ram_we = 1'b1;
                wcnt_d = wcnt_q + LEN_WIDTH'(1);
            end else begin
                trunc_d = 1'b1;
            end
        end
        ack_d = (state_d == ST_GRANT) || (state_d == ST_RECV);
    end

    always_comb begin
        push_desc          = '0;
        push_desc.len      = wcnt_q;
        push_desc.route    = route_q;
        push_desc.bypass   = bypass_q;
        push_desc.protocol = bus.in_protocol;
        push_desc.trunc    = trunc_q;
    end

    assign rd_fire = bus.core_rd && !desc_empty;
    assign rd_last = (rcnt_q == head.len - LEN_WIDTH'(1));
    assign pop     = rd_fire && rd_last;

    always_comb begin
        rptr_d = rptr_q;
        rcnt_d = rcnt_q;
        if (rd_fire) begin
            if (rd_last) begin
                rcnt_d = '0;
                rptr_d = rptr_q + PTR_W'(head.len);
            end else begin
                rcnt_d = rcnt_q + LEN_WIDTH'(1);
            end
        end
        vld_d = rd_fire;
        eop_d = pop;
        dwr_d = dwr_q + DPW'(push);
        drd_d = drd_q + DPW'(pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            wptr_q  <= '0;
            wcnt_q  <= '0;
            trunc_q <= 1'b0;
            rptr_q  <= '0;
            rcnt_q  <= '0;
            vld_q   <= 1'b0;
            eop_q   <= 1'b0;
            dwr_q   <= '0;
            drd_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            wptr_q  <= wptr_d;
            wcnt_q  <= wcnt_d;
            trunc_q <= trunc_d;
            rptr_q  <= rptr_d;
            rcnt_q  <= rcnt_d;
            vld_q   <= vld_d;
            eop_q   <= eop_d;
            dwr_q   <= dwr_d;
            drd_q   <= drd_d;
        end
    end

    always_ff @(posedge clk) begin
        route_q  <= route_d;
        bypass_q <= bypass_d;
        if (push) begin
            desc_mem[dwr_q[DAW-1:0]] <= push_desc;
        end
    end

    pkt_word_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (waddr),
        .wdata (bus.in_data),
        .re    (rd_fire),
        .raddr (raddr),
        .rdata (ram_rdata)
    );

    assign bus.in_ack       = ack_q;
    assign bus.pkt_avail    = !desc_empty;
    assign bus.pkt_len      = desc_empty ? '0 : head.len;
    assign bus.pkt_route    = desc_empty ? '0 : head.route;
    assign bus.pkt_bypass   = !desc_empty && head.bypass;
    assign bus.pkt_protocol = !desc_empty && head.protocol;
    assign bus.pkt_trunc    = !desc_empty && head.trunc;
    assign bus.core_data    = vld_q ? ram_rdata : '0;
    assign bus.core_vld     = vld_q;
    assign bus.core_eop     = eop_q;

`ifdef CORE_PKT_INGRESS_STATS_EN
    logic [31:0] stat_pkts_q, stat_pkts_d;
    logic [31:0] stat_trunc_q, stat_trunc_d;
    logic [31:0] stat_stall_q, stat_stall_d;

    always_comb begin
        stat_pkts_d  = push ? sat_inc(stat_pkts_q) : stat_pkts_q;
        stat_trunc_d = (push && trunc_q) ? sat_inc(stat_trunc_q) : stat_trunc_q;
        stat_stall_d = (state_q == ST_IDLE && bus.in_req && state_d != ST_GRANT)
                       ? sat_inc(stat_stall_q) : stat_stall_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_pkts_q  <= '0;
            stat_trunc_q <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_pkts_q  <= stat_pkts_d;
            stat_trunc_q <= stat_trunc_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign stat_pkts  = stat_pkts_q;
    assign stat_trunc = stat_trunc_q;
    assign stat_stall = stat_stall_q;
`endif
endmodule

// File: tb/tb_core_pkt_ingress.sv
// Directed bench for core_pkt_ingress: table of packets plus hand-written back-pressure, wrap and reset sequences.
module tb_core_pkt_ingress;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    core_pkt_ingress_if bus ();

`ifdef CORE_PKT_INGRESS_STATS_EN
    logic [31:0] stat_pkts, stat_trunc, stat_stall;
`endif

    core_pkt_ingress dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef CORE_PKT_INGRESS_STATS_EN
        ,
        .stat_pkts  (stat_pkts),
        .stat_trunc (stat_trunc),
        .stat_stall (stat_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          n;
        logic [23:0] route;
        logic        bypass;
        logic        proto;
        logic [31:0] base;
        int          exp_len;
        logic        exp_trunc;
    } vec_t;

    vec_t vecs[5];

    function automatic logic [63:0] word(input logic [31:0] base, input int i);
        return {base, 32'(i)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic wait_ack(input int max, output int cycles);
        cycles = -1;
        for (int c = 1; c <= max; c++) begin
            tick();
            if (bus.in_ack) begin
                cycles = c;
                break;
            end
        end
    endtask

    task automatic send_body(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            bus.in_wr   = 1'b1;
            bus.in_data = word(base, i);
            tick();
        end
        // A word offered after in_req drops must not enter the packet.
        bus.in_req  = 1'b0;
        bus.in_wr   = 1'b1;
        bus.in_data = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
        bus.in_wr = 1'b0;
        tick();
    endtask

    task automatic send_pkt(input int n, input logic [23:0] route, input logic bypass,
                            input logic proto, input logic [31:0] base, output int lat);
        bus.in_pkt_route = route;
        bus.in_bypass    = bypass;
        bus.in_protocol  = proto;
        bus.in_req       = 1'b1;
        wait_ack(1000, lat);
        send_body(n, base);
    endtask

    task automatic check_desc(input string tag, input int len, input logic [23:0] route,
                              input logic bypass, input logic proto, input logic trunc);
        check({tag, " avail"}, 64'(bus.pkt_avail), 64'd1);
        check({tag, " len"}, 64'(bus.pkt_len), 64'(len));
        check({tag, " route"}, 64'(bus.pkt_route), 64'(route));
        check({tag, " bypass"}, 64'(bus.pkt_bypass), 64'(bypass));
        check({tag, " proto"}, 64'(bus.pkt_protocol), 64'(proto));
        check({tag, " trunc"}, 64'(bus.pkt_trunc), 64'(trunc));
    endtask

    task automatic drain(input string tag, input int len, input logic [31:0] base);
        for (int i = 0; i < len; i++) begin
            bus.core_rd = 1'b1;
            tick();
            check($sformatf("%s vld w%0d", tag, i), 64'(bus.core_vld), 64'd1);
            check($sformatf("%s data w%0d", tag, i), bus.core_data, word(base, i));
            check($sformatf("%s eop w%0d", tag, i), 64'(bus.core_eop), 64'(i == len - 1));
        end
        bus.core_rd = 1'b0;
    endtask

    initial begin
        int lat;
        int ack_seen;
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        bus.in_data = '0;
        bus.in_pkt_route = '0;
        bus.in_wr = 1'b0;
        bus.in_req = 1'b0;
        bus.in_bypass = 1'b0;
        bus.in_protocol = 1'b0;
        bus.core_rd = 1'b0;

        vecs[0] = '{8,   24'h000003, 1'b1, 1'b1, 32'hA000_0000, 8,   1'b0};
        vecs[1] = '{1,   24'hABCDEF, 1'b0, 1'b0, 32'hA100_0000, 1,   1'b0};
        vecs[2] = '{192, 24'h123456, 1'b0, 1'b1, 32'hA200_0000, 192, 1'b0};
        vecs[3] = '{200, 24'h00FF00, 1'b1, 1'b0, 32'hA300_0000, 192, 1'b1};
        vecs[4] = '{5,   24'h555555, 1'b0, 1'b1, 32'hA400_0000, 5,   1'b0};

        tick();
        tick();
        check("reset in_ack", 64'(bus.in_ack), 64'd0);
        check("reset pkt_avail", 64'(bus.pkt_avail), 64'd0);
        check("reset pkt_len", 64'(bus.pkt_len), 64'd0);
        check("reset core_vld", 64'(bus.core_vld), 64'd0);
        check("reset core_eop", 64'(bus.core_eop), 64'd0);
        check("reset core_data", bus.core_data, 64'd0);
        reset = 1'b1;
        tick();

        // Reads with nothing buffered are ignored.
        bus.core_rd = 1'b1;
        tick();
        bus.core_rd = 1'b0;
        check("idle rd vld", 64'(bus.core_vld), 64'd0);

        for (int v = 0; v < 5; v++) begin
            send_pkt(vecs[v].n, vecs[v].route, vecs[v].bypass, vecs[v].proto, vecs[v].base, lat);
            check($sformatf("vec%0d ack latency", v), 64'(lat), 64'd1);
            check_desc($sformatf("vec%0d", v), vecs[v].exp_len, vecs[v].route,
                       vecs[v].bypass, vecs[v].proto, vecs[v].exp_trunc);
            drain($sformatf("vec%0d", v), vecs[v].exp_len, vecs[v].base);
            tick();
            check($sformatf("vec%0d drained avail", v), 64'(bus.pkt_avail), 64'd0);
        end

        // Request and release without any word: no descriptor.
        send_pkt(0, 24'h777777, 1'b1, 1'b1, 32'h0, lat);
        check("empty pkt ack latency", 64'(lat), 64'd1);
        tick();
        check("empty pkt avail", 64'(bus.pkt_avail), 64'd0);

        // Four 64-word packets fill the descriptor FIFO; the fifth waits for the core.
        for (int p = 0; p < 4; p++) begin
            send_pkt(64, 24'(p + 16), 1'b0, 1'b0, 32'hB000_0000 + 32'(p), lat);
            check($sformatf("bp pkt%0d ack latency", p), 64'(lat), 64'd1);
        end
        check_desc("bp head", 64, 24'd16, 1'b0, 1'b0, 1'b0);
        bus.in_pkt_route = 24'd20;
        bus.in_req = 1'b1;
        ack_seen = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (bus.in_ack) ack_seen = 1;
        end
        check("bp fifth held off", 64'(ack_seen), 64'd0);
        drain("bp pkt0", 64, 32'hB000_0000);
        wait_ack(2, lat);
        check("bp ack after drain", 64'(lat >= 1 && lat <= 2), 64'd1);
        send_body(64, 32'hB000_0004);
        for (int p = 1; p < 5; p++) begin
            check_desc($sformatf("bp pkt%0d", p), 64, 24'(p + 16), 1'b0, 1'b0, 1'b0);
            drain($sformatf("bp pkt%0d", p), 64, 32'hB000_0000 + 32'(p));
        end
        tick();
        check("bp drained avail", 64'(bus.pkt_avail), 64'd0);

        // 540 words through a 512-word RAM crosses the address wrap.
        for (int p = 0; p < 9; p++) begin
            send_pkt(60, 24'(p + 32), 1'b1, 1'b0, 32'hC000_0000 + 32'(p), lat);
            check_desc($sformatf("wrap pkt%0d", p), 60, 24'(p + 32), 1'b1, 1'b0, 1'b0);
            drain($sformatf("wrap pkt%0d", p), 60, 32'hC000_0000 + 32'(p));
        end

        // Reset asserted in the middle of receiving a packet.
        bus.in_pkt_route = 24'h0000AA;
        bus.in_req = 1'b1;
        wait_ack(10, lat);
        for (int i = 0; i < 10; i++) begin
            bus.in_wr = 1'b1;
            bus.in_data = word(32'hD000_0000, i);
            tick();
        end
        reset = 1'b0;
        #1;
        check("mid-recv reset in_ack", 64'(bus.in_ack), 64'd0);
        check("mid-recv reset avail", 64'(bus.pkt_avail), 64'd0);
        bus.in_wr = 1'b0;
        bus.in_req = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("post-reset avail", 64'(bus.pkt_avail), 64'd0);
        send_pkt(6, 24'h0000BB, 1'b0, 1'b1, 32'hE000_0000, lat);
        check("post-reset ack latency", 64'(lat), 64'd1);
        check_desc("post-reset pkt", 6, 24'h0000BB, 1'b0, 1'b1, 1'b0);
`ifdef CORE_PKT_INGRESS_STATS_EN
        check("stat_pkts", 64'(stat_pkts), 64'd1);
        check("stat_trunc", 64'(stat_trunc), 64'd0);
`endif
        drain("post-reset pkt", 6, 32'hE000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
